// File: rtl/airi5c_custom_pkg.sv
// Shared definitions for AIRI5C custom PCPI units: opcode, FSM state encodings,
// funct3 operation codes and instruction decode helpers.
package airi5c_custom_pkg;

  localparam logic [6:0] CUSTOM_OPCODE_DEFAULT = 7'h77;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [2:0] F3_BREV  = 3'b000;
  localparam logic [2:0] F3_BSWAP = 3'b001;
  localparam logic [2:0] F3_CPOP  = 3'b010;
  localparam logic [2:0] F3_CLZ   = 3'b011;
  localparam logic [2:0] F3_ROL   = 3'b100;

  // Unclaimed encodings must leave the core free to raise an illegal-instruction trap.
  function automatic logic insn_claimable(input logic [31:0] insn, input logic [6:0] opcode);
    return (insn[6:0] == opcode) && (insn[31:25] == 7'h00) && (insn[14:12] <= F3_ROL);
  endfunction

  function automatic logic op_is_iterative(input logic [2:0] funct3);
    return (funct3 == F3_CPOP) || (funct3 == F3_CLZ);
  endfunction

endpackage

// File: rtl/airi5c_custom_bitscan.sv
// One step of the iterative CPOP/CLZ datapath: folds a chunk of operand bits
// (MSB first) into the running count.
module airi5c_custom_bitscan
  import airi5c_custom_pkg::*;
#(
  parameter int BITS = 8,
  parameter int AW   = 6
) (
  input  logic [BITS-1:0] chunk,
  input  logic            count_zeros,
  input  logic [AW-1:0]   acc,
  input  logic            found,
  output logic [AW-1:0]   acc_next,
  output logic            found_next
);

  // Walk the chunk from its top bit; CLZ freezes the count once a one has been seen.
  always_comb begin
    acc_next   = acc;
    found_next = found;
    for (int i = BITS - 1; i >= 0; i--) begin
      if (count_zeros) begin
        if (!found_next && !chunk[i]) begin
          acc_next = acc_next + AW'(1'b1);
        end else begin
          acc_next = acc_next;
        end
        found_next = found_next | chunk[i];
      end else begin
        acc_next   = acc_next + AW'(chunk[i]);
        found_next = found_next;
      end
    end
  end

endmodule

// File: rtl/airi5c_custom_bitops.sv
// PCPI coprocessor for bit manipulation: BREV, BSWAP, ROL in one EXEC cycle,
// CPOP and CLZ scanned BITS_PER_CYCLE bits per cycle with fixed latency.
module airi5c_custom_bitops
  import airi5c_custom_pkg::*;
#(
  parameter int         XLEN           = 32,
  parameter int         BITS_PER_CYCLE = 8,
  parameter logic [6:0] OPCODE         = CUSTOM_OPCODE_DEFAULT
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  input  logic [XLEN-1:0] pcpi_rs3,
  output logic            pcpi_wr,
  output logic [XLEN-1:0] pcpi_rd,
  output logic [XLEN-1:0] pcpi_rd2,
  output logic            pcpi_use_rd64,
  output logic            pcpi_wait,
  output logic            pcpi_ready
);

  localparam int STEPS = XLEN / BITS_PER_CYCLE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int AW    = $clog2(XLEN + 1);
  localparam int SW    = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  logic [1:0]      state_r;
  logic [XLEN-1:0] rs1_r;
  logic [SW-1:0]   shamt_r;
  logic [2:0]      funct3_r;
  logic [CW-1:0]   step_r;
  logic [AW-1:0]   acc_r;
  logic            found_r;
  logic [XLEN-1:0] result_r;

  logic            claim_now_s;
  logic [AW-1:0]   acc_next_s;
  logic            found_next_s;
  logic [XLEN-1:0] brev_s;
  logic [XLEN-1:0] bswap_s;
  logic [2*XLEN-1:0] rol_wide_s;
  logic [XLEN-1:0] comb_result_s;
  logic            unused_s;

  assign claim_now_s = (state_r == ST_IDLE) && pcpi_valid && insn_claimable(pcpi_insn, OPCODE);

  // Wait is gated by nreset so every output reads zero while reset is held.
  assign pcpi_wait     = nreset && (claim_now_s || (state_r == ST_EXEC));
  assign pcpi_ready    = (state_r == ST_DONE);
  assign pcpi_wr       = (state_r == ST_DONE);
  assign pcpi_rd       = (state_r == ST_DONE) ? result_r : '0;
  assign pcpi_rd2      = '0;
  assign pcpi_use_rd64 = 1'b0;

  assign unused_s = ^{pcpi_rs3, pcpi_rs2[XLEN-1:SW]};

  airi5c_custom_bitscan #(
    .BITS (BITS_PER_CYCLE),
    .AW   (AW)
  ) u_bitscan (
    .chunk       (rs1_r[XLEN-1 -: BITS_PER_CYCLE]),
    .count_zeros (funct3_r == F3_CLZ),
    .acc         (acc_r),
    .found       (found_r),
    .acc_next    (acc_next_s),
    .found_next  (found_next_s)
  );

  // Single-cycle BREV / BSWAP / ROL from the latched operands.
  always_comb begin
    brev_s  = '0;
    bswap_s = '0;
    for (int i = 0; i < XLEN; i++) begin
      brev_s[i] = rs1_r[XLEN-1-i];
    end
    for (int b = 0; b < XLEN / 8; b++) begin
      bswap_s[8*b +: 8] = rs1_r[XLEN-8-8*b +: 8];
    end
    rol_wide_s = {rs1_r, rs1_r} << shamt_r;
    case (funct3_r)
      F3_BREV:  comb_result_s = brev_s;
      F3_BSWAP: comb_result_s = bswap_s;
      default:  comb_result_s = rol_wide_s[2*XLEN-1:XLEN];
    endcase
  end

  // Control FSM; iterative ops shift rs1_r left so the scanner always sees the top chunk.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r  <= ST_IDLE;
      rs1_r    <= '0;
      shamt_r  <= '0;
      funct3_r <= 3'b000;
      step_r   <= '0;
      acc_r    <= '0;
      found_r  <= 1'b0;
      result_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (claim_now_s) begin
            rs1_r    <= pcpi_rs1;
            shamt_r  <= pcpi_rs2[SW-1:0];
            funct3_r <= pcpi_insn[14:12];
            step_r   <= '0;
            acc_r    <= '0;
            found_r  <= 1'b0;
            result_r <= '0;
            state_r  <= ST_EXEC;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          if (!pcpi_valid) begin
            state_r <= ST_IDLE;
          end else if (op_is_iterative(funct3_r)) begin
            acc_r   <= acc_next_s;
            found_r <= found_next_s;
            rs1_r   <= rs1_r << BITS_PER_CYCLE;
            step_r  <= step_r + CW'(1'b1);
            if (step_r == LAST_STEP) begin
              result_r <= XLEN'(acc_next_s);
              state_r  <= ST_DONE;
            end else begin
              state_r  <= ST_EXEC;
            end
          end else begin
            result_r <= comb_result_s;
            state_r  <= ST_DONE;
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/airi5c_custom_bitops.md
AIRI5C_CUSTOM_BITOPS -- requirements
Module: airi5c_custom_bitops

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width; legal values 32, 64.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 8: bits scanned per EXEC cycle by iterative ops; legal values 1, 2, 4, 8, 16, 32, and XLEN mod BITS_PER_CYCLE = 0.
REQ-003 SHALL have parameter OPCODE, default 7'h77: major opcode claimed.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 nreset  input  1  asynchronous, active-low reset.
REQ-006 pcpi_valid  input  1  core presents an instruction.
REQ-007 pcpi_insn  input  32  instruction word.
REQ-008 pcpi_rs1, pcpi_rs2, pcpi_rs3  input  XLEN each  source operands; rs3 unused.
REQ-009 pcpi_wr  output  1  write rd this cycle.
REQ-010 pcpi_rd  output  XLEN  result.
REQ-011 pcpi_rd2  output  XLEN  tied 0.
REQ-012 pcpi_use_rd64  output  1  tied 0.
REQ-013 pcpi_wait  output  1  instruction claimed, result pending.
REQ-014 pcpi_ready  output  1  result valid, one-cycle pulse.

Function
REQ-015 An instruction SHALL be claimed only if insn[6:0]=OPCODE, insn[31:25]=0 and insn[14:12] is in {000..100}; anything else SHALL leave wait/ready/wr at 0, so the core traps.
REQ-016 funct3 000 BREV: rd = rs1 bit-reversed across XLEN bits.
REQ-017 funct3 001 BSWAP: rd = rs1 byte-reversed across XLEN/8 bytes.
REQ-018 funct3 010 CPOP: rd = number of set bits in rs1, zero-extended.
REQ-019 funct3 011 CLZ: rd = leading zeros of rs1 counted from bit XLEN-1; rs1=0 gives XLEN.
REQ-020 funct3 100 ROL: rd = rs1 rotated left by rs2[log2(XLEN)-1:0]; upper rs2 bits ignored.
REQ-021 States SHALL be IDLE, EXEC, DONE.
REQ-022 IDLE: pcpi_wait = pcpi_valid AND claimed, combinationally; on a claimed instruction, latch rs1, rs2, funct3, clear step counter and accumulator, go to EXEC.
REQ-023 EXEC, ops 000/001/100: one cycle, compute result, go to DONE.
REQ-024 EXEC, ops 010/011: XLEN/BITS_PER_CYCLE cycles, each consuming the next BITS_PER_CYCLE bits MSB-first; CLZ stops counting at the first set bit but still runs all steps (fixed latency).
REQ-025 EXEC: pcpi_wait=1.
REQ-026 DONE: pcpi_ready=1, pcpi_wr=1, pcpi_rd=result for exactly one cycle, then IDLE; pcpi_wait=0.
REQ-027 Latency from claim cycle to ready: 2 cycles for 000/001/100; XLEN/BITS_PER_CYCLE+1 cycles for 010/011.
REQ-028 pcpi_rd SHALL be 0 in every state except DONE.
REQ-029 pcpi_valid falling in EXEC SHALL abort: return to IDLE next cycle, no ready/wr pulse, no claim of further instructions until then.
REQ-030 Operand changes on pcpi_rs1/rs2 after the claim cycle SHALL NOT affect the result.
REQ-031 A new claimed instruction may be accepted in the cycle after DONE; back-to-back ops are independent.

Reset
REQ-032 nreset low SHALL asynchronously force state IDLE, counter 0, latched operands 0, result 0; outputs wr/wait/ready/use_rd64 = 0, rd/rd2 = 0.
REQ-033 Reset asserted mid-EXEC SHALL discard the operation; no ready pulse after release.
REQ-034 First claim SHALL be possible in the first clk edge after nreset deasserts.

Structure
REQ-035 State encodings, funct3 op codes and OPCODE default SHALL live in shared package/header airi5c_custom_pkg, reused by future custom units.
REQ-036 Iterative CPOP/CLZ datapath SHALL be sub-module airi5c_custom_bitscan (inputs: chunk, op, accumulator, found flag; outputs: next accumulator, next found flag); the remainder is one FSM plus combinational BREV/BSWAP/ROL.

Verification
REQ-037 XLEN=32, BPC=8: BREV rs1=32'h0000_0001 -> ready 2 cycles after claim, rd=32'h8000_0000.
REQ-038 BSWAP rs1=32'h1122_3344 -> rd=32'h4433_2211; ROL rs1=32'h8000_0001, rs2=32'h0000_0021 -> rd=32'h0000_0003.
REQ-039 CPOP rs1=32'hF0F0_0001 -> ready 5 cycles after claim, rd=9; CLZ rs1=0 -> rd=32, CLZ rs1=32'h0001_0000 -> rd=15; repeat with BPC=1 -> latency 33.
REQ-040 Invalid: funct7=7'h01 or funct3=3'b111 with opcode 7'h77, and opcode 7'h33 -> wait, ready, wr stay 0 for 40 cycles.
REQ-041 CPOP claimed, pcpi_valid dropped in 2nd EXEC cycle -> no ready; nreset pulsed mid-EXEC in a separate run -> all outputs 0 immediately, no ready after release, next BREV completes correctly.
REQ-042 XLEN=64, BPC=16: CLZ rs1=64'h0000_0000_0000_0001 -> rd=63, latency 5; rs1 changed after claim -> result unchanged.
